// File: rtl/mem_wr_ctrl_pkg.sv
// Shared constants for the row write / bank clear controller.
// Holds the default geometry and the FSM state encoding.
package mem_wr_ctrl_pkg;

   localparam int M_DEF = 4;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

endpackage

// File: rtl/mem_wr_ctrl_if.sv
// Write / clear request bundle plus the bank-facing d/en bus.
// slave: controller side; master: requester side (drives requests).
interface mem_wr_ctrl_if
   import mem_wr_ctrl_pkg::*;
#(
   parameter int M = M_DEF
);

   localparam int N = 2 ** M;

   logic         wr_valid;
   logic         wr_ready;
   logic [M-1:0] wr_addr;
   logic [N-1:0] wr_data;
   logic         clr_start;
   logic         busy;
   logic         clr_done;
   logic [N-1:0] d;
   logic [N-1:0] en;

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      input  clr_start,
      output wr_ready,
      output busy,
      output clr_done,
      output d,
      output en
   );

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      output clr_start,
      input  wr_ready,
      input  busy,
      input  clr_done,
      input  d,
      input  en
   );

endinterface

// File: rtl/mem_wr_ctrl_onehot_dec.sv
// M-bit index to 2**M one-hot decoder.
// Ports: idx (row index in), oh (one-hot row select out).
module onehot_dec
   import mem_wr_ctrl_pkg::*;
#(
   parameter int M = M_DEF
) (
   input  logic [M-1:0]    idx,
   output logic [2**M-1:0] oh
);

   always_comb begin
      oh      = '0;
      oh[idx] = 1'b1;
   end

endmodule

// File: rtl/mem_wr_ctrl.sv
// Row write / whole-bank clear controller driving a bank's d and en.
// Ports: clk, rst (sync, active high), bus (request side + d/en).
module mem_wr_ctrl
   import mem_wr_ctrl_pkg::*;
#(
   parameter int M = M_DEF
) (
   input logic           clk,
   input logic           rst,
   mem_wr_ctrl_if.slave  bus
);

   localparam int N = 2 ** M;

   logic [0:0]   state;
   logic [M-1:0] row;
   logic [N-1:0] en_q;
   logic [N-1:0] d_q;
   logic         done_q;
   logic [M-1:0] idx;
   logic [N-1:0] sel;
   logic         wr_fire;

   // Writes only happen in IDLE, so one decoder serves both paths.
   assign idx = (state == CLEAR) ? row : bus.wr_addr;

   onehot_dec #(.M(M)) u_dec (
      .idx (idx),
      .oh  (sel)
   );

   // Clear request wins over a simultaneous write.
   assign bus.wr_ready = (state == IDLE) && !bus.clr_start;
   assign wr_fire      = bus.wr_valid && bus.wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         row    <= '0;
         en_q   <= '0;
         d_q    <= '0;
         done_q <= 1'b0;
      end else begin
         en_q   <= '0;
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (bus.clr_start) begin
               state <= CLEAR;
               row   <= '0;
            end else if (wr_fire) begin
               en_q <= sel;
               d_q  <= bus.wr_data;
            end
         end else begin
            en_q <= sel;
            d_q  <= '0;
            if (row == '1) begin
               // Last row registered: leave without wrapping.
               state  <= IDLE;
               row    <= '0;
               done_q <= 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end

   assign bus.busy     = (state == CLEAR);
   assign bus.clr_done = done_q;
   assign bus.en       = en_q;
   assign bus.d        = d_q;

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Self-checking bench for mem_wr_ctrl with an attached 16x16 bank model.
// Directed vector table plus hand-written clear / reset sequences.
module tb_mem_wr_ctrl;

   localparam int M = 4;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [N-1:0] bank [N];

   always #5 clk = ~clk;

   mem_wr_ctrl_if #(.M(M)) bus ();

   mem_wr_ctrl #(.M(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Bank: shared data input, one write enable per row.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (bus.en[i]) bank[i] <= bus.d;
   end

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // en must never carry more than one bit.
   always @(negedge clk) begin
      check("en_onehot", ($countones(bus.en) > 1) ? 32'd1 : 32'd0, 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic         v;
      logic [M-1:0] a;
      logic [N-1:0] wd;
      logic         clr;
      logic         rdy;
      logic [N-1:0] en;
      logic [N-1:0] d;
      logic         busy;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b1, 4'd5,  16'hA5A5, 1'b0, 1'b1, 16'h0020, 16'hA5A5, 1'b0};
      tbl[1] = '{1'b0, 4'd5,  16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0};
      tbl[2] = '{1'b1, 4'd0,  16'h1111, 1'b0, 1'b1, 16'h0001, 16'h1111, 1'b0};
      tbl[3] = '{1'b1, 4'd15, 16'h2222, 1'b0, 1'b1, 16'h8000, 16'h2222, 1'b0};
      tbl[4] = '{1'b1, 4'd3,  16'h3333, 1'b0, 1'b1, 16'h0008, 16'h3333, 1'b0};
      tbl[5] = '{1'b0, 4'd3,  16'h0000, 1'b0, 1'b1, 16'h0000, 16'h3333, 1'b0};
      tbl[6] = '{1'b1, 4'd2,  16'hBEEF, 1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0};
      tbl[7] = '{1'b0, 4'd2,  16'h0000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0};

      bus.wr_valid  = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clr_start = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_en", 32'(bus.en), 32'h0);
      check("rst_d", 32'(bus.d), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.clr_done), 32'h0);
      check("rst_ready", 32'(bus.wr_ready), 32'h1);
      rst = 1'b0;
      tick();

      // Table-driven writes, including back-to-back
      for (int i = 0; i < 8; i++) begin
         bus.wr_valid  = tbl[i].v;
         bus.wr_addr   = tbl[i].a;
         bus.wr_data   = tbl[i].wd;
         bus.clr_start = tbl[i].clr;
         #1;
         check($sformatf("vec%0d_ready", i), 32'(bus.wr_ready),
               32'(tbl[i].rdy));
         tick();
         check($sformatf("vec%0d_en", i), 32'(bus.en), 32'(tbl[i].en));
         check($sformatf("vec%0d_d", i), 32'(bus.d), 32'(tbl[i].d));
         check($sformatf("vec%0d_busy", i), 32'(bus.busy),
               32'(tbl[i].busy));
      end
      check("bank_w5", 32'(bank[5]), 32'hA5A5);
      check("bank_w15", 32'(bank[15]), 32'h2222);

      // Clear together with a write to row 7: clear wins
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 4'd7;
      bus.wr_data   = 16'h7777;
      bus.clr_start = 1'b1;
      #1;
      check("clr_wr_ready", 32'(bus.wr_ready), 32'h0);
      tick();
      bus.clr_start = 1'b0;
      #1;
      check("c0_en", 32'(bus.en), 32'h0);
      check("c0_d", 32'(bus.d), 32'hBEEF);
      check("c0_busy", 32'(bus.busy), 32'h1);
      check("c0_done", 32'(bus.clr_done), 32'h0);
      check("c0_ready", 32'(bus.wr_ready), 32'h0);
      for (int i = 0; i < N; i++) begin
         bus.clr_start = (i == 5);
         tick();
         bus.clr_start = 1'b0;
         #1;
         check($sformatf("sw%0d_en", i), 32'(bus.en), 32'h1 << i);
         check($sformatf("sw%0d_d", i), 32'(bus.d), 32'h0);
         check($sformatf("sw%0d_busy", i), 32'(bus.busy),
               (i == N - 1) ? 32'h0 : 32'h1);
         check($sformatf("sw%0d_done", i), 32'(bus.clr_done),
               (i == N - 1) ? 32'h1 : 32'h0);
         check($sformatf("sw%0d_ready", i), 32'(bus.wr_ready),
               (i == N - 1) ? 32'h1 : 32'h0);
         if (i == N - 2) bus.wr_valid = 1'b0;
      end
      tick();
      check("post_en", 32'(bus.en), 32'h0);
      check("post_busy", 32'(bus.busy), 32'h0);
      check("post_done", 32'(bus.clr_done), 32'h0);
      for (int r = 0; r < N; r++)
         check($sformatf("clr_row%0d", r), 32'(bank[r]), 32'h0);

      // Writes after the clear read back
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 4'd9;
      bus.wr_data  = 16'h1234;
      tick();
      bus.wr_addr  = 4'd7;
      bus.wr_data  = 16'hC0DE;
      tick();
      bus.wr_valid = 1'b0;
      tick();
      tick();
      check("rb_row9", 32'(bank[9]), 32'h1234);
      check("rb_row7", 32'(bank[7]), 32'hC0DE);
      check("rb_row5", 32'(bank[5]), 32'h0);

      // Reset at sweep row 6 aborts without clr_done
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("ab_en_row5", 32'(bus.en), 32'h0020);
      rst = 1'b1;
      tick();
      check("ab_en", 32'(bus.en), 32'h0);
      check("ab_busy", 32'(bus.busy), 32'h0);
      check("ab_d", 32'(bus.d), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("ab%0d_done", i), 32'(bus.clr_done), 32'h0);
         check($sformatf("ab%0d_en", i), 32'(bus.en), 32'h0);
      end

      // Reset has priority over clr_start and wr_valid
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 4'd4;
      bus.wr_data   = 16'h5555;
      bus.clr_start = 1'b1;
      rst           = 1'b1;
      tick();
      check("pri_en", 32'(bus.en), 32'h0);
      check("pri_busy", 32'(bus.busy), 32'h0);
      check("pri_d", 32'(bus.d), 32'h0);
      rst           = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.clr_start = 1'b0;
      tick();
      check("pri_idle_busy", 32'(bus.busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
